// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencing controller.
// Optional feature macro: SHIFT_SEQ_ZFLAG_EN (adds the rsp_zero output on the top).
package shift_seq_pkg;

  localparam int WIDTH = 6;
  localparam int AMT_W = 3;

  // Opcodes understood by the shared 6-bit shift register; 7 is never driven.
  typedef enum logic [2:0] {
    SH_HOLD = 3'd0,
    SH_ASR  = 3'd1,
    SH_SHL  = 3'd2,
    SH_ROR  = 3'd3,
    SH_ROL  = 3'd4,
    SH_CLR  = 3'd5,
    SH_LOAD = 3'd6
  } sh_op_e;

  // Command encoding used by the requesters.
  typedef enum logic [1:0] {
    CMD_ASR = 2'd0,
    CMD_SHL = 2'd1,
    CMD_ROR = 2'd2,
    CMD_ROL = 2'd3
  } shift_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Translate a requester command into the shifter opcode it needs.
  function automatic sh_op_e cmd_to_op(input shift_cmd_e cmd);
    case (cmd)
      CMD_ASR: return SH_ASR;
      CMD_SHL: return SH_SHL;
      CMD_ROR: return SH_ROR;
      default: return SH_ROL;
    endcase
  endfunction

endpackage

// File: rtl/shift_seq_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that did not win last time.
module shift_seq_rr_arb
  import shift_seq_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Grant selection; nothing is granted while the controller is busy.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (en) begin
      case (req_valid)
        2'b01: begin
          grant     = 2'b01;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant     = 2'b10;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_idx = ~last;
          grant     = last ? 2'b01 : 2'b10;
        end
        default: begin
          grant     = 2'b00;
          grant_idx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the shared 6-bit shift register: arbitrates two
// requesters, loads the operand, steps the shift opcode amt times and returns
// the result on a valid/ready response channel.
// Optional feature macro: SHIFT_SEQ_ZFLAG_EN adds rsp_zero (result-is-zero flag).
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][1:0]       req_cmd,
  input  logic [1:0][AMT_W-1:0] req_amt,
  input  logic [1:0][WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [2:0]            sh_op,
  output logic [WIDTH-1:0]      sh_din,
  input  logic [WIDTH-1:0]      sh_dout
`ifdef SHIFT_SEQ_ZFLAG_EN
  ,
  output logic                  rsp_zero
`endif
);

  seq_state_e       state_q, state_d;
  shift_cmd_e       cmd_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             last_q;

  logic [1:0]       grant;
  logic             grant_idx;
  logic             accept;

  // Reset is gated into the enable so no command is accepted while rst is high.
  shift_seq_rr_arb u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .en        ((state_q == ST_IDLE) && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = (cnt_q != '0) ? ST_SHIFT : ST_RESP;
      ST_SHIFT: if (cnt_q == AMT_W'(1)) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, step counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= CMD_ASR;
      cnt_q  <= '0;
      data_q <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else if (accept) begin
      cmd_q  <= shift_cmd_e'(req_cmd[grant_idx]);
      cnt_q  <= req_amt[grant_idx];
      data_q <= req_data[grant_idx];
      id_q   <= grant_idx;
      last_q <= grant_idx;
    end else if (state_q == ST_SHIFT) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Outputs: shifter control and response channel; reset forces CLR and
  // masks the response so a stale RESP never leaks out.
  always_comb begin
    sh_op     = SH_HOLD;
    sh_din    = '0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    if (rst) begin
      sh_op = SH_CLR;
    end else begin
      case (state_q)
        ST_LOAD: begin
          sh_op  = SH_LOAD;
          sh_din = data_q;
        end
        ST_SHIFT: sh_op = cmd_to_op(cmd_q);
        ST_RESP: begin
          rsp_valid = 1'b1;
          rsp_id    = id_q;
          rsp_data  = sh_dout;
        end
        default: sh_op = SH_HOLD;
      endcase
    end
  end

`ifdef SHIFT_SEQ_ZFLAG_EN
  // Zero flag qualifies the response; rsp_valid is already low in reset.
  assign rsp_zero = rsp_valid && (rsp_data == '0);
`else
  // Zero flag not built.
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl with a behavioural model of the
// shared shift register. Define SHIFT_SEQ_ZFLAG_EN to also exercise rsp_zero.
module tb_shift_seq_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_cmd;
  logic [1:0][2:0] req_amt;
  logic [1:0][5:0] req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [5:0]      rsp_data;
  logic [2:0]      sh_op;
  logic [5:0]      sh_din;
  logic [5:0]      sh_dout;
`ifdef SHIFT_SEQ_ZFLAG_EN
  logic            rsp_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_amt   (req_amt),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .sh_op     (sh_op),
    .sh_din    (sh_din),
    .sh_dout   (sh_dout)
`ifdef SHIFT_SEQ_ZFLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  // Shift register model, pre-loaded with all ones.
  logic [5:0] sh_q = 6'b111111;
  assign sh_dout = sh_q;
  always @(posedge clk) begin
    case (sh_op)
      3'd1: sh_q <= {sh_q[5], sh_q[5:1]};
      3'd2: sh_q <= {sh_q[4:0], 1'b0};
      3'd3: sh_q <= {sh_q[0], sh_q[5:1]};
      3'd4: sh_q <= {sh_q[4:0], sh_q[5]};
      3'd5: sh_q <= 6'b000000;
      3'd6: sh_q <= sh_din;
      default: sh_q <= sh_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from requester idx, starting in IDLE at #1 after an edge,
  // and check latency, shifter opcodes and the response.
  task automatic do_cmd(input string tag, input int idx, input logic [1:0] cmd,
                        input logic [2:0] amt, input logic [5:0] data, input logic [5:0] exp);
    int cyc;
    req_valid      = 2'b00;
    req_valid[idx] = 1'b1;
    req_cmd[idx]   = cmd;
    req_amt[idx]   = amt;
    req_data[idx]  = data;
    #1;
    check({tag, "_ready"}, req_ready, 2'b01 << idx);
    tick();
    req_valid = 2'b00;
    req_data  = '1;
    check({tag, "_load_op"}, sh_op, 3'd6);
    check({tag, "_load_din"}, sh_din, data);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
      if (!rsp_valid) check({tag, "_shift_op"}, sh_op, {1'b0, cmd} + 3'd1);
    end
    check({tag, "_latency"}, cyc, amt + 2);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_id"}, rsp_id, idx);
    check({tag, "_resp_op"}, sh_op, 3'd0);
`ifdef SHIFT_SEQ_ZFLAG_EN
    check({tag, "_zero"}, rsp_zero, exp == 6'd0);
`endif
    tick();
    check({tag, "_idle_valid"}, rsp_valid, 1'b0);
    check({tag, "_idle_data"}, rsp_data, 6'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic [5:0] held;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_cmd   = '0;
    req_amt   = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset: shifter is cleared, nothing is accepted.
    #1;
    check("rst_op", sh_op, 3'd5);
    check("rst_ready", req_ready, 2'b00);
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;
    #1;
    check("post_rst_dout", sh_dout, 6'b000000);
    check("post_rst_op", sh_op, 3'd0);
    check("post_rst_valid", rsp_valid, 1'b0);
    check("post_rst_id", rsp_id, 1'b0);
    check("post_rst_data", rsp_data, 6'd0);
    check("post_rst_din", sh_din, 6'd0);

    // Single-requester commands, all four shift kinds plus amt 0.
    do_cmd("asr2", 0, 2'd0, 3'd2, 6'b101011, 6'b111010);
    do_cmd("amt0", 0, 2'd1, 3'd0, 6'b101011, 6'b101011);
    do_cmd("shl3", 1, 2'd1, 3'd3, 6'b101011, 6'b011000);
    do_cmd("ror1", 1, 2'd2, 3'd1, 6'b101011, 6'b110101);
    do_cmd("rol2", 1, 2'd3, 3'd2, 6'b101011, 6'b101110);

    // Both requesters valid: grants alternate 0,1,0,1; back-pressure on the second.
    req_cmd   = {2'd1, 2'd1};
    req_amt   = {3'd1, 3'd1};
    req_data  = {6'b110000, 6'b000011};
    req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
        tick();
        cyc++;
      end
      check("rr_got_rsp", rsp_valid, 1'b1);
      check("rr_id", rsp_id, r[0]);
      check("rr_data", rsp_data, r[0] ? 6'b100000 : 6'b000110);
      check("rr_ready_busy", req_ready, 2'b00);
      if (r == 1) begin
        rsp_ready = 1'b0;
        held      = rsp_data;
        repeat (5) begin
          tick();
          check("bp_valid", rsp_valid, 1'b1);
          check("bp_data", rsp_data, held);
          check("bp_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
      end
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Reset in the middle of a SHIFT: no response, shifter cleared.
    req_cmd[0]  = 2'd1;
    req_amt[0]  = 3'd5;
    req_data[0] = 6'b000001;
    req_valid   = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("mid_shifting", sh_op, 3'd2);
    rst       = 1'b1;
    req_valid = 2'b01;
    #1;
    check("mid_rst_op", sh_op, 3'd5);
    check("mid_rst_ready", req_ready, 2'b00);
    check("mid_rst_valid", rsp_valid, 1'b0);
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;
    #1;
    check("mid_post_op", sh_op, 3'd0);
    check("mid_post_dout", sh_dout, 6'd0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", seen, 1'b0);
    do_cmd("fresh", 0, 2'd3, 3'd1, 6'b000000, 6'b000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
